sumador_serial: RTL and testbench

SUMADOR_SERIAL -- requirements
Module: sumador_serial

---
 rtl/arit_pkg.sv | 15 +
 rtl/sumador_serial_if.sv | 27 ++
 rtl/sum1b.sv | 16 +
 rtl/sumador_serial.sv | 99 +++++++++
 tb/tb_sumador_serial.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arit_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width,
// common to the serial adder and the combinational subtractor.
package arit_pkg;

  // Default operand/result width in bits
  localparam int WIDTH_DEF = 5;

  // Serial adder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage : arit_pkg

// File: rtl/sumador_serial_if.sv
// Handshake and data bundle of the serial adder: start request and operands in,
// result, carry, busy and done pulse out.
interface sumador_serial_if #(
  parameter int WIDTH = arit_pkg::WIDTH_DEF
);

  logic             inicio;
  logic [WIDTH-1:0] sumando_a;
  logic [WIDTH-1:0] sumando_b;
  logic [WIDTH-1:0] suma;
  logic             Cout;
  logic             ocupado;
  logic             listo;

  // Requester side: issues operations and observes results
  modport master (
    output inicio, sumando_a, sumando_b,
    input  suma, Cout, ocupado, listo
  );

  // Adder side: accepts operations and produces results
  modport slave (
    input  inicio, sumando_a, sumando_b,
    output suma, Cout, ocupado, listo
  );

endinterface : sumador_serial_if

// File: rtl/sum1b.sv
// One-bit full adder, the only arithmetic element of the serial datapath.
module sum1b (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Cout,
  output logic Sum
);

  logic w_p;

  assign w_p  = A ^ B;
  assign Sum  = w_p ^ Ci;
  assign Cout = (A & B) | (Ci & w_p);

endmodule : sum1b

// File: rtl/sumador_serial.sv
// Bit-serial adder: one operand bit per clock through a single full adder,
// LSB first, with a registered result/carry presented once per operation.
module sumador_serial
  import arit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  sumador_serial_if.slave  bus
);

  // Counter is wide enough to hold WIDTH itself, not just WIDTH-1
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_suma;
  logic             r_cout;
  logic             r_ocupado;
  logic             r_listo;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;

  // Current bit pair plus the stored carry
  sum1b u_sum1b (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Ci   (r_carry),
    .Cout (w_carry),
    .Sum  (w_sum)
  );

  // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  // Control FSM and serial datapath; all outputs come straight from registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_suma    <= '0;
      r_cout    <= 1'b0;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
    end else begin
      r_listo <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.inicio) begin
            r_a       <= bus.sumando_a;
            r_b       <= bus.sumando_b;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
            r_state   <= SUMA;
          end
        end
        SUMA: begin
          r_res   <= w_res_next;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_suma    <= w_res_next;
            r_cout    <= w_carry;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b1;
            r_state   <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.suma    = r_suma;
  assign bus.Cout    = r_cout;
  assign bus.ocupado = r_ocupado;
  assign bus.listo   = r_listo;

endmodule : sumador_serial

// File: tb/tb_sumador_serial.sv
// Self-checking bench for the serial adder: directed scenarios plus a random
// sweep, compared against plain integer addition and fixed-latency rules.
module tb_sumador_serial;

  localparam int W   = 5;
  localparam int LAT = W;        // edges from capture to listo
  localparam int GAP = W + 2;    // start-to-start spacing with inicio held

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sumador_serial_if #(.WIDTH(W)) bus ();

  sumador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and reports latency, busy cycles, result hold and trailing listo
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy,
                        output logic post_listo, output bit held);
    logic [W:0] prev;
    prev = {bus.Cout, bus.suma};
    held = 1'b1;
    busy = 0;
    lat  = 0;
    bus.inicio    = 1'b1;
    bus.sumando_a = a;
    bus.sumando_b = b;
    tick();
    bus.inicio    = 1'b0;
    bus.sumando_a = W'($urandom);
    bus.sumando_b = W'($urandom);
    if (bus.ocupado) busy++;
    while (!bus.listo && lat < 40) begin
      if ({bus.Cout, bus.suma} !== prev) held = 1'b0;
      tick();
      lat++;
      bus.sumando_a = W'($urandom);
      bus.sumando_b = W'($urandom);
      if (bus.ocupado) busy++;
    end
    tick();
    post_listo = bus.listo;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.inicio    = 1'b1;
    bus.sumando_a = 5'd3;
    bus.sumando_b = 5'd3;
    repeat (3) tick();
    n_checks++; if (bus.suma !== '0) begin n_fail++; $display("FAIL reset_suma: got %0d, required 0", bus.suma); end
    n_checks++; if (bus.Cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b, required 0", bus.Cout); end
    n_checks++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b, required 0", bus.ocupado); end
    n_checks++; if (bus.listo !== 1'b0) begin n_fail++; $display("FAIL reset_listo: got %b, required 0", bus.listo); end
    bus.inicio = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, busy; logic pl; bit held;
    run_op(5'd7, 5'd9, lat, busy, pl, held);
    $display("basic: 7+9 -> suma=%0d Cout=%b lat=%0d busy=%0d", bus.suma, bus.Cout, lat, busy);
    n_checks++; if (bus.suma !== 5'd16) begin n_fail++; $display("FAIL basic_suma: got %0d, required 16", bus.suma); end
    n_checks++; if (bus.Cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b, required 0", bus.Cout); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d, required %0d", lat, LAT); end
    n_checks++; if (busy !== W) begin n_fail++; $display("FAIL basic_ocupado_cycles: got %0d, required %0d", busy, W); end
    n_checks++; if (pl !== 1'b0) begin n_fail++; $display("FAIL basic_listo_width: got %b after one cycle, required 0", pl); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    int lat, busy; logic pl; bit held;
    logic [W:0] exp_v;
    ta[0] = 5'd31; tb[0] = 5'd1;
    ta[1] = 5'd31; tb[1] = 5'd31;
    ta[2] = 5'd0;  tb[2] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      exp_v = (W+1)'(int'(ta[i]) + int'(tb[i]));
      run_op(ta[i], tb[i], lat, busy, pl, held);
      $display("overflow: %0d+%0d -> suma=%0d Cout=%b", ta[i], tb[i], bus.suma, bus.Cout);
      n_checks++;
      if ({bus.Cout, bus.suma} !== exp_v) begin
        n_fail++;
        $display("FAIL overflow_%0d: got Cout=%b suma=%0d, required Cout=%b suma=%0d",
                 i, bus.Cout, bus.suma, exp_v[W], exp_v[W-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_listo;
    int   pulses;
    pulses = 0;
    bus.inicio    = 1'b1;
    bus.sumando_a = 5'd3;
    bus.sumando_b = 5'd4;
    for (int e = 0; e <= 26; e++) begin
      tick();
      exp_listo = (e >= LAT) && (((e - LAT) % GAP) == 0);
      n_checks++;
      if (bus.listo !== exp_listo) begin
        n_fail++;
        $display("FAIL b2b_listo_edge%0d: got %b, required %b", e, bus.listo, exp_listo);
      end
      if (bus.listo) begin
        pulses++;
        $display("b2b: listo at edge %0d suma=%0d Cout=%b", e, bus.suma, bus.Cout);
        n_checks++;
        if ({bus.Cout, bus.suma} !== 6'd7) begin
          n_fail++;
          $display("FAIL b2b_result_edge%0d: got Cout=%b suma=%0d, required 0/7", e, bus.Cout, bus.suma);
        end
      end
      if (bus.ocupado) begin
        bus.sumando_a = W'($urandom);
        bus.sumando_b = W'($urandom);
      end else begin
        bus.sumando_a = 5'd3;
        bus.sumando_b = 5'd4;
      end
    end
    bus.inicio = 1'b0;
    tick();
    n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d, required 4", pulses); end
  endtask

  task automatic test_ignore_inicio();
    int extra;
    bus.inicio    = 1'b1;
    bus.sumando_a = 5'd10;
    bus.sumando_b = 5'd11;
    tick();
    for (int e = 1; e <= LAT + 1; e++) begin
      bus.inicio    = (e == 2) || (e == LAT + 1);
      bus.sumando_a = W'($urandom);
      bus.sumando_b = W'($urandom);
      tick();
      if (e == LAT) begin
        $display("ignore: listo=%b suma=%0d Cout=%b", bus.listo, bus.suma, bus.Cout);
        n_checks++;
        if (bus.listo !== 1'b1 || {bus.Cout, bus.suma} !== 6'd21) begin
          n_fail++;
          $display("FAIL ignore_result: got listo=%b Cout=%b suma=%0d, required 1/0/21", bus.listo, bus.Cout, bus.suma);
        end
      end
    end
    bus.inicio = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.listo || bus.ocupado) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_extra_op: got %0d busy/listo cycles, required 0", extra); end
    n_checks++; if ({bus.Cout, bus.suma} !== 6'd21) begin n_fail++; $display("FAIL ignore_hold: got suma=%0d, required 21", bus.suma); end
  endtask

  task automatic test_reset_abort();
    int lat, busy; logic pl; bit held;
    bus.inicio    = 1'b1;
    bus.sumando_a = 5'd12;
    bus.sumando_b = 5'd5;
    tick();
    bus.inicio = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("abort: after reset suma=%0d Cout=%b ocupado=%b listo=%b", bus.suma, bus.Cout, bus.ocupado, bus.listo);
    n_checks++;
    if (bus.suma !== '0 || bus.Cout !== 1'b0 || bus.ocupado !== 1'b0 || bus.listo !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got suma=%0d Cout=%b ocupado=%b listo=%b, required all 0",
               bus.suma, bus.Cout, bus.ocupado, bus.listo);
    end
    run_op(5'd12, 5'd5, lat, busy, pl, held);
    $display("abort: restart 12+5 -> suma=%0d Cout=%b lat=%0d", bus.suma, bus.Cout, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL abort_restart_latency: got %0d, required %0d", lat, LAT); end
    n_checks++; if ({bus.Cout, bus.suma} !== 6'd17) begin n_fail++; $display("FAIL abort_restart_result: got Cout=%b suma=%0d, required 0/17", bus.Cout, bus.suma); end
  endtask

  task automatic test_random();
    int lat, busy; logic pl; bit held;
    logic [W-1:0] a, b;
    logic [W:0]   exp_v;
    int           bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp_v = (W+1)'(int'(a) + int'(b));
      run_op(a, b, lat, busy, pl, held);
      n_checks++;
      if ({bus.Cout, bus.suma} !== exp_v || lat !== LAT || !held) begin
        n_fail++;
        bad++;
        $display("FAIL random_%0d: %0d+%0d got Cout=%b suma=%0d lat=%0d held=%0d, required Cout=%b suma=%0d lat=%0d held=1",
                 i, a, b, bus.Cout, bus.suma, lat, held, exp_v[W], exp_v[W-1:0], LAT);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("random: 1000 operations, %0d wrong", bad);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.inicio    = 1'b0;
    bus.sumando_a = '0;
    bus.sumando_b = '0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_ignore_inicio();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sumador_serial
